// File: rtl/ddr_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_pattern_tx_if
//  Description : Control and DDR lane bundle for the pattern transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr_pattern_tx_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [LEN_W-1:0] burst_len;
    logic [7:0]       d_rise;
    logic [7:0]       d_fall;
    logic             valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] sent_count;

    modport master (
        output start, abort, mode, burst_len,
        input  d_rise, d_fall, valid, busy, done, sent_count
    );

    modport slave (
        input  start, abort, mode, burst_len,
        output d_rise, d_fall, valid, busy, done, sent_count
    );
endinterface
`default_nettype wire

// File: rtl/ddr_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_pattern_tx
//  Description : Framed DDR test-pattern burst generator (sync preamble + data).
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_pattern_tx #(
    parameter int         LEN_W     = 16,
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ddr_pattern_tx_if.slave   bus
);
    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_sync0  = 3'd1;
    localparam logic [2:0]  c_st_sync1  = 3'd2;
    localparam logic [2:0]  c_st_data   = 3'd3;
    localparam logic [2:0]  c_st_done   = 3'd4;
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    logic [2:0]       r_state;
    logic [1:0]       r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_sent_count;
    logic [15:0]      r_lfsr;
    logic [7:0]       r_d_rise;
    logic [7:0]       r_d_fall;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_cnt_inc;
    logic [15:0]      w_lfsr_step;
    logic [15:0]      w_beat0_word;
    logic [15:0]      w_next_word;

    // Returns {rise, fall} for beat index idx (only idx mod 128 matters).
    function automatic logic [15:0] beat_word(
        input logic [1:0]  m,
        input logic [6:0]  idx,
        input logic [15:0] lfsr
    );
        logic [7:0] walk;
        walk = 8'h01 << idx[2:0];
        case (m)
            2'd0:    beat_word = {idx, 1'b0, idx, 1'b1};
            2'd1:    beat_word = lfsr;
            2'd2:    beat_word = {walk, ~walk};
            default: beat_word = {8'h55, 8'hAA};
        endcase
    endfunction

    // sent_count doubles as the beat index: it equals i while beat i is shown.
    assign w_cnt_inc    = r_sent_count + 1'b1;
    assign w_lfsr_step  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_beat0_word = beat_word(r_mode, 7'd0, r_lfsr);
    assign w_next_word  = beat_word(r_mode, w_cnt_inc[6:0], w_lfsr_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_mode       <= 2'd0;
            r_len        <= '0;
            r_sent_count <= '0;
            r_lfsr       <= c_lfsr_seed;
            r_d_rise     <= 8'h00;
            r_d_fall     <= 8'h00;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (bus.abort && (r_state != c_st_idle)) begin
            r_state  <= c_st_idle;
            r_d_rise <= 8'h00;
            r_d_fall <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_d_rise <= 8'h00;
                    r_d_fall <= 8'h00;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        r_state      <= c_st_sync0;
                        r_mode       <= bus.mode;
                        r_len        <= bus.burst_len;
                        r_sent_count <= '0;
                        r_lfsr       <= c_lfsr_seed;
                        r_d_rise     <= SYNC_WORD;
                        r_d_fall     <= ~SYNC_WORD;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                c_st_sync0: begin
                    r_state  <= c_st_sync1;
                    r_d_rise <= SYNC_WORD;
                    r_d_fall <= ~SYNC_WORD;
                    r_valid  <= 1'b1;
                end
                c_st_sync1: begin
                    if (r_len != '0) begin
                        r_state                <= c_st_data;
                        {r_d_rise, r_d_fall}   <= w_beat0_word;
                        r_valid                <= 1'b1;
                    end else begin
                        r_state  <= c_st_done;
                        r_d_rise <= 8'h00;
                        r_d_fall <= 8'h00;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                c_st_data: begin
                    r_sent_count <= w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        r_state  <= c_st_done;
                        r_d_rise <= 8'h00;
                        r_d_fall <= 8'h00;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        {r_d_rise, r_d_fall} <= w_next_word;
                        r_lfsr               <= w_lfsr_step;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_rise     = r_d_rise;
    assign bus.d_fall     = r_d_fall;
    assign bus.valid      = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sent_count = r_sent_count;
endmodule
`default_nettype wire

// File: tb/tb_ddr_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_pattern_tx
//  Description : Directed self-checking bench for ddr_pattern_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_pattern_tx;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ddr_pattern_tx_if #(.LEN_W(16)) ifc ();

    ddr_pattern_tx #(.LEN_W(16), .SYNC_WORD(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // {valid, busy, done, d_rise, d_fall}
    logic [18:0] obs;
    assign obs = {ifc.valid, ifc.busy, ifc.done, ifc.d_rise, ifc.d_fall};

    localparam logic [18:0] c_sync = {3'b110, 8'hA5, 8'h5A};
    localparam logic [18:0] c_done = {3'b011, 16'h0000};
    localparam logic [18:0] c_idle = 19'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch a burst; returns at the negedge inside the SYNC0 cycle.
    task automatic start_burst(input logic [1:0] m, input logic [15:0] l);
        ifc.start     = 1'b1;
        ifc.mode      = m;
        ifc.burst_len = l;
        @(negedge clk);
        ifc.start     = 1'b0;
        ifc.mode      = ~m;
        ifc.burst_len = l + 16'd37;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.start = 1'b0; ifc.abort = 1'b0; ifc.mode = 2'd0; ifc.burst_len = 16'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== c_idle) begin n_bad++; $display("FAIL reset outputs: got %h want %h", obs, c_idle); end
        n_cmp++;
        if (ifc.sent_count !== 16'd0) begin n_bad++; $display("FAIL reset sent_count: got %0d want 0", ifc.sent_count); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.mode = k[1:0];
            ifc.burst_len = 16'(k * 7 + 1);
            @(negedge clk);
            n_cmp++;
            if (obs !== c_idle) begin n_bad++; $display("FAIL idle no start %0d: got %h want %h", k, obs, c_idle); end
        end
    endtask

    task automatic test_counter();
        logic [7:0] er [4] = '{8'h00, 8'h02, 8'h04, 8'h06};
        logic [7:0] ef [4] = '{8'h01, 8'h03, 8'h05, 8'h07};
        start_burst(2'd0, 16'd4);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (obs !== c_sync) begin n_bad++; $display("FAIL counter sync %0d: got %h want %h", c, obs, c_sync); end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs !== {3'b110, er[i], ef[i]}) begin
                n_bad++; $display("FAIL counter beat %0d: got %h want %h", i, obs, {3'b110, er[i], ef[i]});
            end
            n_cmp++;
            if (ifc.sent_count !== 16'(i)) begin
                n_bad++; $display("FAIL counter sent_count beat %0d: got %0d want %0d", i, ifc.sent_count, i);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (obs !== c_done) begin n_bad++; $display("FAIL counter done: got %h want %h", obs, c_done); end
        n_cmp++;
        if (ifc.sent_count !== 16'd4) begin n_bad++; $display("FAIL counter final count: got %0d want 4", ifc.sent_count); end
        @(negedge clk);
        n_cmp++;
        if (obs !== c_idle) begin n_bad++; $display("FAIL counter back to idle: got %h want %h", obs, c_idle); end
        n_cmp++;
        if (ifc.sent_count !== 16'd4) begin n_bad++; $display("FAIL counter count hold: got %0d want 4", ifc.sent_count); end
    endtask

    task automatic test_prbs();
        logic [15:0] ew [3] = '{16'hACE1, 16'h59C3, 16'hB387};
        start_burst(2'd1, 16'd3);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (obs !== c_sync) begin n_bad++; $display("FAIL prbs sync %0d: got %h want %h", c, obs, c_sync); end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== {3'b110, ew[i]}) begin
                n_bad++; $display("FAIL prbs beat %0d: got %h want %h", i, obs, {3'b110, ew[i]});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (obs !== c_done) begin n_bad++; $display("FAIL prbs done: got %h want %h", obs, c_done); end
        @(negedge clk);
    endtask

    task automatic test_walk_toggle();
        logic [7:0] er [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        start_burst(2'd2, 16'd10);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (obs !== {3'b110, er[i], ~er[i]}) begin
                n_bad++; $display("FAIL walk beat %0d: got %h want %h", i, obs, {3'b110, er[i], ~er[i]});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (obs !== c_done) begin n_bad++; $display("FAIL walk done: got %h want %h", obs, c_done); end
        @(negedge clk);
        start_burst(2'd3, 16'd1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 8'h55, 8'hAA}) begin n_bad++; $display("FAIL toggle beat: got %h want %h", obs, {3'b110, 8'h55, 8'hAA}); end
        @(negedge clk);
        n_cmp++;
        if (obs !== c_done || ifc.sent_count !== 16'd1) begin
            n_bad++; $display("FAIL toggle done: got %h/%0d want %h/1", obs, ifc.sent_count, c_done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len_and_ignore();
        start_burst(2'd0, 16'd0);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (obs !== c_sync) begin n_bad++; $display("FAIL zero-len sync %0d: got %h want %h", c, obs, c_sync); end
            @(negedge clk);
        end
        n_cmp++;
        if (obs !== c_done || ifc.sent_count !== 16'd0) begin
            n_bad++; $display("FAIL zero-len done: got %h/%0d want %h/0", obs, ifc.sent_count, c_done);
        end
        @(negedge clk);
        n_cmp++;
        if (obs !== c_idle) begin n_bad++; $display("FAIL zero-len idle: got %h want %h", obs, c_idle); end
        // Start pulses during DATA and during DONE must be ignored.
        start_burst(2'd3, 16'd3);
        repeat (2) @(negedge clk);
        ifc.start = 1'b1; ifc.mode = 2'd0; ifc.burst_len = 16'd9;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (obs !== {3'b110, 8'h55, 8'hAA}) begin
                n_bad++; $display("FAIL ignore-start beat %0d: got %h want %h", i, obs, {3'b110, 8'h55, 8'hAA});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (obs !== c_done) begin n_bad++; $display("FAIL ignore-start done: got %h want %h", obs, c_done); end
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs !== c_idle || ifc.sent_count !== 16'd3) begin
                n_bad++; $display("FAIL no second burst %0d: got %h/%0d want %h/3", c, obs, ifc.sent_count, c_idle);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        start_burst(2'd0, 16'd20);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 8'h0A, 8'h0B} || ifc.sent_count !== 16'd5) begin
            n_bad++; $display("FAIL abort pre beat5: got %h/%0d want %h/5", obs, ifc.sent_count, {3'b110, 8'h0A, 8'h0B});
        end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        n_cmp++;
        if (obs !== c_idle) begin n_bad++; $display("FAIL abort outputs: got %h want %h", obs, c_idle); end
        n_cmp++;
        if (ifc.sent_count !== 16'd5) begin n_bad++; $display("FAIL abort sent_count: got %0d want 5", ifc.sent_count); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== c_idle) begin n_bad++; $display("FAIL abort no done %0d: got %h want %h", c, obs, c_idle); end
        end
        ifc.start = 1'b1; ifc.abort = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0; ifc.abort = 1'b0;
        n_cmp++;
        if (obs !== c_idle || ifc.sent_count !== 16'd5) begin
            n_bad++; $display("FAIL abort+start idle: got %h/%0d want %h/5", obs, ifc.sent_count, c_idle);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        start_burst(2'd1, 16'd20);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 16'h59C3} || ifc.sent_count !== 16'd1) begin
            n_bad++; $display("FAIL rst-mid pre beat1: got %h/%0d want %h/1", obs, ifc.sent_count, {3'b110, 16'h59C3});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (obs !== c_idle || ifc.sent_count !== 16'd0) begin
            n_bad++; $display("FAIL rst-mid outputs: got %h/%0d want %h/0", obs, ifc.sent_count, c_idle);
        end
        start_burst(2'd1, 16'd1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== {3'b110, 16'hACE1}) begin n_bad++; $display("FAIL rst-mid reseed: got %h want %h", obs, {3'b110, 16'hACE1}); end
        @(negedge clk);
        n_cmp++;
        if (obs !== c_done) begin n_bad++; $display("FAIL rst-mid done: got %h want %h", obs, c_done); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_counter();
        test_prbs();
        test_walk_toggle();
        test_zero_len_and_ignore();
        test_abort();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/ddr_pattern_tx.md
# ddr_pattern_tx

Transmit-side companion to the DDR input throughput tester. It generates a framed burst of known test patterns as paired rising-edge and falling-edge bytes, which feed a downstream DDR output mux/pad cell. Each burst starts with a two-beat sync preamble so the receiver can align, then sends a programmable number of data beats. The receiver checks the stream and counts throughput.

## Interface

Parameters:
- LEN_W, 16, width of burst length and beat counter
- SYNC_WORD, 8'hA5, preamble byte on the rising lane; the falling lane carries its complement

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send a burst; honoured only in IDLE
- abort  in  1  terminates any burst; highest priority after rst
- mode  in  2  pattern select; latched on accepted start
- burst_len  in  LEN_W  number of data beats; latched on accepted start
- d_rise  out  8  byte for the rising-edge DDR slot
- d_fall  out  8  byte for the falling-edge DDR slot
- valid  out  1  d_rise/d_fall carry a preamble or data beat this cycle
- busy  out  1  burst in progress (SYNC0, SYNC1, DATA, DONE)
- done  out  1  one-cycle pulse at normal burst completion
- sent_count  out  LEN_W  data beats sent in current/last burst

## Operation

- All outputs are registered. Reset values: d_rise=0, d_fall=0, valid=0, busy=0, done=0, sent_count=0. FSM goes to IDLE and LFSR goes to 16'hACE1.
- States: IDLE, SYNC0, SYNC1, DATA, DONE.
- IDLE: valid=0, d_rise/d_fall=0. On start: latch mode and burst_len, clear sent_count and beat index, load LFSR=16'hACE1, go to SYNC0.
- SYNC0 and SYNC1: valid=1, d_rise=SYNC_WORD, d_fall=~SYNC_WORD. SYNC1 goes to DATA if latched len≠0, otherwise to DONE.
- DATA: valid=1, one beat per cycle, beat index i = 0..len-1. sent_count increments after each beat. After beat len-1, go to DONE.
- DONE: valid=0, done=1, busy=1 for one cycle, then IDLE.
- Patterns by latched mode (i is the beat index; arithmetic is mod 256):
  - 0, counter: d_rise=2i, d_fall=2i+1.
  - 1, PRBS: 16-bit Fibonacci LFSR, taps 16,14,13,11. Each beat outputs d_rise=lfsr[15:8], d_fall=lfsr[7:0]. LFSR then advances: lfsr<={lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. Beat 0 is the seed.
  - 2, walking one: d_rise=8'h01<<(i mod 8), d_fall=~d_rise.
  - 3, toggle: d_rise=8'h55, d_fall=8'hAA.
- start while busy (any non-IDLE state, including DONE) is ignored. The latched values do not change.
- abort in any non-IDLE state: next cycle is IDLE with valid=0, busy=0, no done pulse. sent_count holds the beats already sent.
- abort and start together in IDLE: abort wins and start is dropped.
- rst during a burst: identical to the reset values above, next cycle.
- mode/burst_len changes after start have no effect on the running burst.
- sent_count holds its final value in IDLE until the next accepted start. With burst_len=2^LEN_W−1 the counter reaches its max and does not wrap.

## Timing

- start sampled high at edge k in IDLE. SYNC0 appears in the cycle after edge k, SYNC1 in the cycle after edge k+1, data beat 0 in the cycle after edge k+2.
- Data beat len-1 appears in the cycle after edge k+1+len. done is high in the cycle after edge k+2+len. IDLE follows one cycle later.
- A new start is accepted earliest at the edge where the FSM is in IDLE, so the minimum start-to-start spacing is len+4 cycles.
- Throughput: one data beat (16 bits) per clk in DATA, with no bubbles.
- sent_count equals i+1 in the cycle after beat i is presented.

## Test plan

- Reset then idle: rst for 2 cycles -> all outputs 0, state IDLE; toggling mode/burst_len without start -> valid stays 0.
- Mode 0, burst_len=4: start -> A5/5A, A5/5A, then 00/01, 02/03, 04/05, 06/07, then done=1 for one cycle; sent_count=4.
- Mode 1, burst_len=3: data beats AC/E1, 59/C3, then the next LFSR step (B3/87); valid continuous, no gaps.
- Mode 2, burst_len=10: d_rise sequence 01,02,04,…,80,01,02 with d_fall its complement. Mode 3, burst_len=1 gives 55/AA.
- burst_len=0: start -> exactly two sync beats, then done, sent_count=0. A start pulse during DATA or DONE is ignored, with no second burst.
- Abort during data beat 5 of a burst_len=20 burst -> next cycle valid=0, busy=0, done never asserted, sent_count=5. Repeat with rst mid-burst -> sent_count=0.
